// File: rtl/rs_write_forward_param_if.sv
// Operand-capture bus for the reservation-station write-forward buffer.
// The slave side is the buffer itself; the master side is the issue logic
// that presents operands and the consumer that drains resolved entries.
interface rs_write_forward_param_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_FU     = 10,
  parameter int DEPTH      = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_WIDTH-1:0]        oldData;
  logic [3:0]                   fuFwd;
  logic [3:0]                   fuuFwd;
  logic [NUM_FU*DATA_WIDTH-1:0] fu_bus;
  logic [NUM_FU*DATA_WIDTH-1:0] fu_reg_bus;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        newData;
  logic                         sel_err;
  logic [CNT_W-1:0]             count;

  modport slave (
    input  flush, in_valid, oldData, fuFwd, fuuFwd, fu_bus, fu_reg_bus,
           out_ready,
    output in_ready, out_valid, newData, sel_err, count
  );

  modport master (
    output flush, in_valid, oldData, fuFwd, fuuFwd, fu_bus, fu_reg_bus,
           out_ready,
    input  in_ready, out_valid, newData, sel_err, count
  );
endinterface

// File: rtl/rs_write_forward_param.sv
// Reservation-station operand capture with result forwarding.
// At accept time the operand is resolved from the current FU result bus,
// the one-cycle-old registered result bus, or the register-file value, and
// the resolved value is frozen into a small circular FIFO. The consumer
// drains the FIFO with a valid/ready handshake.
module rs_write_forward_param #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_FU     = 10,
  parameter int DEPTH      = 2
) (
  input logic                     clk,
  input logic                     rst,
  rs_write_forward_param_if.slave bus
);

  localparam int                SEL_W = 4;
  localparam logic [SEL_W-1:0]  NONE  = 4'hf;
  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [SEL_W-1:0]  NUM_FU_SEL = SEL_W'(NUM_FU);

  // Select points at an existing functional unit.
  function automatic logic sel_hit(input logic [SEL_W-1:0] s);
    return s < NUM_FU_SEL;
  endfunction

  // Select is neither "no forward" nor a real functional unit.
  function automatic logic sel_bad(input logic [SEL_W-1:0] s);
    return (s != NONE) && !sel_hit(s);
  endfunction

  // Extract slice s of a result bus; out-of-range selects yield zero.
  function automatic logic [DATA_WIDTH-1:0] bus_slice(
    input logic [NUM_FU*DATA_WIDTH-1:0] b,
    input logic [SEL_W-1:0]             s
  );
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (s == SEL_W'(k)) v = b[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return v;
  endfunction

  // Priority: current-cycle result, then previous-cycle result, then RF value.
  function automatic logic [DATA_WIDTH-1:0] resolve_operand(
    input logic [SEL_W-1:0]             fwd,
    input logic [SEL_W-1:0]             fwd_old,
    input logic [NUM_FU*DATA_WIDTH-1:0] cur_bus,
    input logic [NUM_FU*DATA_WIDTH-1:0] reg_bus,
    input logic [DATA_WIDTH-1:0]        rf_val
  );
    if (sel_hit(fwd))          return bus_slice(cur_bus, fwd);
    else if (sel_hit(fwd_old)) return bus_slice(reg_bus, fwd_old);
    else                       return rf_val;
  endfunction

  // ---- stage p0: combinational resolve and handshake decode ----
  logic [DATA_WIDTH-1:0] res_data_p0;
  logic                  acc_p0;
  logic                  pop_p0;
  logic                  bad_sel_p0;

  // ---- stage p1: buffer storage and control state ----
  logic [DATA_WIDTH-1:0] buf_p1 [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_p1;
  logic [CNT_W-1:0]      count_nxt;
  logic                  sel_err_p1;
  logic                  vld_p1;

  assign vld_p1 = (count_p1 != '0);

  // Handshake outputs; a full buffer still accepts when the head leaves.
  assign bus.in_ready  = (count_p1 < DEPTH_CNT) || bus.out_ready;
  assign bus.out_valid = vld_p1;
  assign bus.newData   = vld_p1 ? buf_p1[rd_ptr] : '0;
  assign bus.sel_err   = sel_err_p1;
  assign bus.count     = count_p1;

  // Resolve the operand and decode accept/pop for this cycle.
  always_comb begin
    res_data_p0 = resolve_operand(bus.fuFwd, bus.fuuFwd, bus.fu_bus,
                                  bus.fu_reg_bus, bus.oldData);
    acc_p0      = bus.in_valid && bus.in_ready;
    pop_p0      = vld_p1 && bus.out_ready;
    bad_sel_p0  = sel_bad(bus.fuFwd) || sel_bad(bus.fuuFwd);
  end

  // Occupancy follows the accept/pop pair; both together keep it constant.
  always_comb begin
    count_nxt = count_p1;
    unique case ({acc_p0, pop_p0})
      2'b10:   count_nxt = count_p1 + CNT_W'(1);
      2'b01:   count_nxt = count_p1 - CNT_W'(1);
      default: count_nxt = count_p1;
    endcase
  end

  // Control state: pointers, occupancy and the sticky select-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_p1   <= '0;
      sel_err_p1 <= 1'b0;
    end else begin
      if (acc_p0 && bad_sel_p0) sel_err_p1 <= 1'b1;
      if (bus.flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count_p1 <= '0;
      end else begin
        if (acc_p0) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_p0) rd_ptr <= rd_ptr + PTR_W'(1);
        count_p1 <= count_nxt;
      end
    end
  end

  // Operand storage: the resolved value is frozen here on accept.
  always_ff @(posedge clk) begin
    if (acc_p0 && !bus.flush) buf_p1[wr_ptr] <= res_data_p0;
  end

endmodule

// File: tb/tb_rs_write_forward_param.sv
// Directed bench for the write-forward operand buffer. Two instances are
// exercised: a DEPTH=2 buffer for forwarding, backpressure, select errors
// and reset, and a DEPTH=4 buffer for pointer wrap and flush.
module tb_rs_write_forward_param;

  localparam int DW = 64;
  localparam int NF = 10;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] ea;
  logic [63:0] eb;

  rs_write_forward_param_if #(.DATA_WIDTH(DW), .NUM_FU(NF), .DEPTH(2)) ia ();
  rs_write_forward_param_if #(.DATA_WIDTH(DW), .NUM_FU(NF), .DEPTH(4)) ib ();

  rs_write_forward_param #(.DATA_WIDTH(DW), .NUM_FU(NF), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );
  rs_write_forward_param #(.DATA_WIDTH(DW), .NUM_FU(NF), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for instance A.
  always @(negedge clk) begin
    if (!rst) begin
      if (ia.flush) qa.delete();
      else if (ia.out_valid && ia.out_ready) begin
        total++;
        if (qa.size() == 0) begin
          bad++;
          $display("FAIL popA unexpected got=%0h", ia.newData);
        end else begin
          ea = qa.pop_front();
          if (ia.newData !== ea) begin
            bad++;
            $display("FAIL popA got=%0h want=%0h", ia.newData, ea);
          end
        end
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin
    if (!rst) begin
      if (ib.flush) qb.delete();
      else if (ib.out_valid && ib.out_ready) begin
        total++;
        if (qb.size() == 0) begin
          bad++;
          $display("FAIL popB unexpected got=%0h", ib.newData);
        end else begin
          eb = qb.pop_front();
          if (ib.newData !== eb) begin
            bad++;
            $display("FAIL popB got=%0h want=%0h", ib.newData, eb);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ia.flush = 0; ia.in_valid = 0; ia.oldData = '0; ia.fuFwd = 4'hf;
    ia.fuuFwd = 4'hf; ia.fu_bus = '0; ia.fu_reg_bus = '0; ia.out_ready = 0;
    ib.flush = 0; ib.in_valid = 0; ib.oldData = '0; ib.fuFwd = 4'hf;
    ib.fuuFwd = 4'hf; ib.fu_bus = '0; ib.fu_reg_bus = '0; ib.out_ready = 0;
    #2;
    // Reset state, observed before any clock edge.
    check("rst_count",    64'(ia.count),     64'd0);
    check("rst_out_valid",64'(ia.out_valid), 64'd0);
    check("rst_in_ready", 64'(ia.in_ready),  64'd1);
    check("rst_sel_err",  64'(ia.sel_err),   64'd0);
    check("rst_newData",  ia.newData,        64'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Priority: current bus beats registered bus.
    ia.fuFwd = 4'd3; ia.fuuFwd = 4'd5;
    ia.fu_bus[3*DW +: DW] = 64'hAAAA; ia.fu_reg_bus[5*DW +: DW] = 64'hBBBB;
    ia.in_valid = 1; ia.out_ready = 1;
    qa.push_back(64'hAAAA);
    tick();
    ia.in_valid = 0;
    ia.fu_bus[3*DW +: DW] = 64'hDEAD;
    check("prio_out_valid", 64'(ia.out_valid), 64'd1);
    check("prio_count",     64'(ia.count),     64'd1);
    tick();
    check("prio_drained",   64'(ia.count),     64'd0);

    // Fallbacks: RF value, then registered bus slice 9.
    ia.fuFwd = 4'hf; ia.fuuFwd = 4'hf; ia.oldData = 64'h1234; ia.in_valid = 1;
    qa.push_back(64'h1234);
    tick();
    ia.fuuFwd = 4'd9; ia.fu_reg_bus[9*DW +: DW] = 64'h55; ia.oldData = 64'h0;
    qa.push_back(64'h55);
    tick();
    ia.in_valid = 0; ia.fuuFwd = 4'hf;
    tick();
    check("fallback_drained", 64'(ia.count), 64'd0);

    // Full buffer and backpressure.
    ia.out_ready = 0; ia.in_valid = 1; ia.oldData = 64'd1;
    qa.push_back(64'd1);
    tick();
    check("bp_count1", 64'(ia.count), 64'd1);
    ia.oldData = 64'd2;
    qa.push_back(64'd2);
    tick();
    ia.oldData = 64'd3;
    check("bp_count2",   64'(ia.count),    64'd2);
    check("bp_in_ready", 64'(ia.in_ready), 64'd0);
    tick();
    check("bp_hold_count",   64'(ia.count), 64'd2);
    check("bp_hold_newData", ia.newData,    64'd1);
    ia.out_ready = 1;
    #1;
    check("bp_ready_on_pop", 64'(ia.in_ready), 64'd1);
    qa.push_back(64'd3);
    tick();
    check("bp_swap_count", 64'(ia.count), 64'd2);
    ia.in_valid = 0;
    tick();
    tick();
    check("bp_drained", 64'(ia.count), 64'd0);

    // Illegal select falls through to RF and sets the sticky flag.
    ia.out_ready = 0; ia.fuFwd = 4'd12; ia.fuuFwd = 4'hf; ia.oldData = 64'd7;
    ia.in_valid = 1;
    qa.push_back(64'd7);
    check("ill_sel_err_before", 64'(ia.sel_err), 64'd0);
    tick();
    ia.in_valid = 0; ia.fuFwd = 4'hf;
    check("ill_sel_err",  64'(ia.sel_err), 64'd1);
    check("ill_newData",  ia.newData,      64'd7);
    ia.out_ready = 1;
    tick();
    ia.out_ready = 0; ia.in_valid = 1; ia.oldData = 64'h61;
    qa.push_back(64'h61);
    tick();
    ia.oldData = 64'h62;
    qa.push_back(64'h62);
    tick();
    ia.in_valid = 0; ia.flush = 1; ia.out_ready = 1;
    tick();
    ia.flush = 0; ia.out_ready = 0;
    check("ill_flush_count",  64'(ia.count),     64'd0);
    check("ill_flush_valid",  64'(ia.out_valid), 64'd0);
    check("ill_flush_sticky", 64'(ia.sel_err),   64'd1);

    // Pointer wrap on the DEPTH=4 instance.
    ib.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      ib.in_valid = 1; ib.oldData = 64'(16 + i);
      qb.push_back(64'(16 + i));
      tick();
    end
    ib.in_valid = 0;
    tick();
    check("wrap_drained", 64'(ib.count), 64'd0);
    ib.out_ready = 0; ib.in_valid = 1; ib.oldData = 64'h20;
    qb.push_back(64'h20);
    tick();
    ib.oldData = 64'h21;
    qb.push_back(64'h21);
    tick();
    ib.in_valid = 0;
    check("wrap_count",   64'(ib.count), 64'd2);
    check("wrap_newData", ib.newData,    64'h20);

    // Flush with a same-cycle capture and pop request.
    ib.flush = 1; ib.in_valid = 1; ib.oldData = 64'h99; ib.out_ready = 1;
    tick();
    ib.flush = 0; ib.in_valid = 0;
    check("flush_count", 64'(ib.count),     64'd0);
    check("flush_valid", 64'(ib.out_valid), 64'd0);
    tick();
    check("flush_not_stored", 64'(ib.count), 64'd0);
    ib.in_valid = 1; ib.oldData = 64'h77;
    qb.push_back(64'h77);
    tick();
    ib.in_valid = 0;
    check("post_flush_count",   64'(ib.count), 64'd1);
    check("post_flush_newData", ib.newData,    64'h77);
    tick();
    check("post_flush_drained", 64'(ib.count), 64'd0);

    // Asynchronous reset with two entries buffered.
    ia.out_ready = 0; ia.in_valid = 1; ia.oldData = 64'h31;
    qa.push_back(64'h31);
    tick();
    ia.oldData = 64'h32;
    qa.push_back(64'h32);
    tick();
    ia.in_valid = 0;
    check("arst_pre_count", 64'(ia.count), 64'd2);
    #3;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    check("arst_out_valid", 64'(ia.out_valid), 64'd0);
    check("arst_count",     64'(ia.count),     64'd0);
    check("arst_newData",   ia.newData,        64'd0);
    check("arst_in_ready",  64'(ia.in_ready),  64'd1);
    check("arst_sel_err",   64'(ia.sel_err),   64'd0);
    tick();
    tick();
    rst = 1'b0;
    check("rel_in_ready", 64'(ia.in_ready), 64'd1);
    tick();
    ia.in_valid = 1; ia.oldData = 64'h41;
    qa.push_back(64'h41);
    tick();
    ia.in_valid = 0;
    check("rel_count",   64'(ia.count), 64'd1);
    check("rel_newData", ia.newData,    64'h41);
    ia.out_ready = 1;
    tick();
    ia.out_ready = 0;
    check("rel_drained", 64'(ia.count), 64'd0);

    check("qa_empty", 64'(qa.size()), 64'd0);
    check("qb_empty", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_write_forward_param.md
RS_WRITE_FORWARD_PARAM -- requirements
Module: rs_write_forward_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: operand data width in bits.
REQ-002 SHALL have parameter NUM_FU, default 10, range 1..15: number of functional-unit result buses.
REQ-003 SHALL have parameter DEPTH, default 2, power of two, range 2..8: number of captured-operand buffer entries.
REQ-004 SHALL have derived localparam SEL_W = 4 and select value NONE = 4'hf, meaning "no forward from this bus".
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 flush  in  1  synchronous discard of all buffered entries.
REQ-008 in_valid  in  1  capture request.
REQ-009 in_ready  out  1  buffer can accept this cycle.
REQ-010 oldData  in  DATA_WIDTH  register-file operand value.
REQ-011 fuFwd  in  4  current-cycle forward select.
REQ-012 fuuFwd  in  4  previous-cycle forward select.
REQ-013 fu_bus  in  NUM_FU*DATA_WIDTH  current results; FU k occupies slice k.
REQ-014 fu_reg_bus  in  NUM_FU*DATA_WIDTH  registered, one-cycle-old results; same slicing.
REQ-015 out_valid  out  1  head entry valid.
REQ-016 out_ready  in  1  consumer takes head entry.
REQ-017 newData  out  DATA_WIDTH  head entry data.
REQ-018 sel_err  out  1  sticky illegal-select flag.
REQ-019 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-020 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-021 Operand resolution SHALL be combinational at accept time, with the following priority:
  - fuFwd < NUM_FU: slice fuFwd of fu_bus.
  - else fuuFwd < NUM_FU: slice fuuFwd of fu_reg_bus.
  - else oldData.
REQ-022 The resolved value SHALL be written into the buffer on the accept edge; the buses SHALL NOT be re-sampled afterwards.
REQ-023 A select that is neither NONE nor < NUM_FU SHALL contribute zero for that source; resolution then falls to the next priority.
REQ-024 An illegal select on an accepted capture SHALL set sel_err on the next edge; sel_err SHALL clear only on rst.
REQ-025 The buffer SHALL be a circular FIFO with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-026 in_ready SHALL equal (count < DEPTH) || out_ready. This allows accept while full only when a pop occurs in the same cycle.
REQ-027 out_valid SHALL equal (count != 0); newData SHALL be the entry at rd_ptr and SHALL be held stable while out_valid && !out_ready.
REQ-028 Latency from accept to out_valid SHALL be 1 cycle when empty; there SHALL be no combinational in-to-out bypass.
REQ-029 Simultaneous accept and pop SHALL leave count unchanged and advance both pointers.
REQ-030 A pop when empty and an accept when full without a pop SHALL NOT occur by construction and SHALL NOT change state.
REQ-031 flush SHALL set count, wr_ptr and rd_ptr to 0 on the next edge.
REQ-032 flush SHALL override same-cycle accept and pop.
REQ-033 flush SHALL NOT clear sel_err.
REQ-034 Buffer data storage SHALL need no reset; only control state and outputs SHALL reset.

Reset
REQ-035 rst high SHALL immediately, without waiting for clk, force count=0, pointers=0, out_valid=0, sel_err=0 and newData=0.
REQ-036 Reset SHALL force in_ready=1 while rst is asserted and after release.
REQ-037 Reset asserted mid-operation SHALL discard all entries; the first accept after release SHALL appear as the sole entry.
REQ-038 Reset release SHALL be synchronous to clk at the bench level; the block SHALL tolerate release one cycle before the first in_valid.

Verification
REQ-039 Priority: DATA_WIDTH=64, NUM_FU=10; fuFwd=3, fuuFwd=5, fu_bus[3]=0xAAAA, fu_reg_bus[5]=0xBBBB, accept -> next cycle out_valid=1, newData=0xAAAA.
REQ-040 Fallback: fuFwd=NONE, fuuFwd=NONE, oldData=0x1234 -> newData=0x1234; fuFwd=NONE, fuuFwd=9, fu_reg_bus[9]=0x55 -> newData=0x55.
REQ-041 Full/backpressure: DEPTH=2, out_ready=0, three accept attempts of 1, 2, 3 -> count=2, in_ready=0 on the third; then out_ready=1 with in_valid held -> pops 1 and accepts 3 in one cycle, count stays 2, outputs 1, 2, 3 in order.
REQ-042 Illegal select: NUM_FU=10, fuFwd=12, fuuFwd=NONE, oldData=7 -> newData=7, sel_err=1 next cycle; sel_err persists through flush and clears only on rst.
REQ-043 Flush/wrap: run 5 accept/pop pairs with DEPTH=4 so pointers wrap; assert flush with in_valid=1 -> count=0, out_valid=0 next cycle, and the flushed-cycle capture is not stored.
REQ-044 Async reset: assert rst between clock edges while count=2 -> out_valid=0, count=0 before the next edge; newData=0.
